fetch_queue: RTL

Parametrised instruction-fetch front end for the KGP-RISC core. It is the successor to the single-step next-instruction sequencer.
- Owns the program counter and issues word-addressed reads to a synchronous instruction memory with 1-cycle read latency.
- Buffers fetched words in a DEPTH-entry prefetch queue.
- Hands instructions to decode over a valid/ready handshake.
- Supports branch/jump redirect with flush, and halt.

---
 rtl/kgp_fetch_pkg.sv | 22 ++
 rtl/fetch_queue_if.sv | 28 ++
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_queue.sv | 125 ++++++++++++
 4 files changed

// File: rtl/kgp_fetch_pkg.sv
// kgp_fetch_pkg: shared constants, helpers and types for the KGP-RISC fetch front end.
//   ADDR_W_DEF / INSTR_W_DEF : default word-address and instruction widths
//   log2_depth()             : pointer width for a power-of-two queue depth
//   fetch_entry_t            : queue entry {instr, pc} at the default widths
package kgp_fetch_pkg;

   localparam int ADDR_W_DEF  = 8;
   localparam int INSTR_W_DEF = 32;

   function automatic int log2_depth(input int depth);
      int r;
      r = 0;
      while ((1 << r) < depth) r++;
      return r;
   endfunction

   typedef struct packed {
      logic [INSTR_W_DEF-1:0] instr;
      logic [ADDR_W_DEF-1:0]  pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction-memory read port plus decode handshake.
//   imem_en/imem_addr -> memory, imem_rdata <- memory (1-cycle latency)
//   dec_valid/dec_instr/dec_pc -> decode, dec_ready <- decode
//   master: fetch front end; slave: memory + decode side
interface fetch_queue_if
   import kgp_fetch_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF
);
   logic               imem_en;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic               dec_valid;
   logic [INSTR_W-1:0] dec_instr;
   logic [ADDR_W-1:0]  dec_pc;
   logic               dec_ready;

   modport master (
      output imem_en, imem_addr, dec_valid, dec_instr, dec_pc,
      input  imem_rdata, dec_ready
   );

   modport slave (
      input  imem_en, imem_addr, dec_valid, dec_instr, dec_pc,
      output imem_rdata, dec_ready
   );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: generic synchronous FIFO with flush.
//   clk, rst_n        : clock, async active-low reset
//   push/wr_data      : write tail (accepted when not full, or full with pop)
//   pop               : remove head (ignored when empty)
//   flush             : discard all entries, takes priority over push
//   rd_data           : head entry; while empty it holds the last entry presented
//   full, empty, count: occupancy status
module fetch_fifo
   import kgp_fetch_pkg::*;
#(
   parameter  int WIDTH = 40,
   parameter  int DEPTH = 4,
   localparam int PTR_W = log2_depth(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr, prev_ptr, rd_next;
   logic [CNT_W-1:0] count_q;
   logic             do_pop, do_push;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign count   = count_q;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign prev_ptr = rd_ptr - PTR_W'(1);
   assign rd_next  = rd_ptr + PTR_W'(1);

   // The slot behind rd_ptr is never overwritten while empty, so it still holds
   // the entry that was last on the output.
   assign rd_data = empty ? mem[prev_ptr] : mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         // Step past the displayed head so it becomes the held value.
         rd_ptr  <= empty ? rd_ptr : rd_next;
         wr_ptr  <= empty ? rd_ptr : rd_next;
         count_q <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) rd_ptr <= rd_next;
         count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: KGP-RISC instruction-fetch front end with DEPTH-entry prefetch queue.
//   clk, rst_n      : clock, async active-low reset
//   bus (master)    : imem read port and decode valid/ready handshake
//   redirect_valid/redirect_addr : taken branch/jump, flushes queue and in-flight read
//   halt            : level, blocks new fetches
//   line_no         : pc of most recently accepted instruction
//   empty           : queue empty and nothing in flight
// Optional (FETCH_PERF_EN): perf_fetched, perf_flushed saturating 32-bit counters.
module fetch_queue
   import kgp_fetch_pkg::*;
#(
   parameter int                ADDR_W     = ADDR_W_DEF,
   parameter int                INSTR_W    = INSTR_W_DEF,
   parameter int                DEPTH      = 4,
   parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   fetch_queue_if.master     bus,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_addr,
   input  logic              halt,
   output logic [ADDR_W-1:0] line_no,
   output logic              empty
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]       perf_fetched,
   output logic [31:0]       perf_flushed
`endif
);

   localparam int CNT_W = log2_depth(DEPTH) + 1;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } entry_t;

   logic [ADDR_W-1:0] pc, inflight_pc;
   logic              epoch, inflight, inflight_epoch;
   logic              issue, pop, push, room;
   logic [CNT_W-1:0]  fifo_count, occ_after;
   logic              fifo_full, fifo_empty;
   entry_t            wr_entry, head;

   assign pop = !fifo_empty && bus.dec_ready;

   // Entries plus outstanding read once this cycle's pop is taken.
   assign occ_after = fifo_count - CNT_W'(pop) + CNT_W'(inflight);
   assign room      = (!fifo_full || pop) && (occ_after < CNT_W'(DEPTH));

   // rst_n gates the strobe so no read leaves while reset is held.
   assign issue = rst_n && !halt && !redirect_valid && room;

   // Redirect blocks issue, so the tag check only matters if that ever changes;
   // the flush already drops a read returning in the redirect cycle.
   assign push = inflight && (inflight_epoch == epoch);

   assign wr_entry.instr = bus.imem_rdata;
   assign wr_entry.pc    = inflight_pc;

   fetch_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .wr_data (wr_entry),
      .pop     (pop),
      .flush   (redirect_valid),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc             <= START_ADDR;
         epoch          <= 1'b0;
         inflight       <= 1'b0;
         inflight_epoch <= 1'b0;
         inflight_pc    <= '0;
         line_no        <= '0;
      end else begin
         if (pop) line_no <= head.pc;
         inflight <= issue;
         if (redirect_valid) begin
            pc    <= redirect_addr;
            epoch <= ~epoch;
         end else if (issue) begin
            pc             <= pc + ADDR_W'(1);
            inflight_pc    <= pc;
            inflight_epoch <= epoch;
         end
      end
   end

   assign bus.imem_en   = issue;
   assign bus.imem_addr = pc;
   assign bus.dec_valid = !fifo_empty;
   assign bus.dec_instr = head.instr;
   assign bus.dec_pc    = head.pc;
   assign empty         = fifo_empty && !inflight;

`ifdef FETCH_PERF_EN
   logic [32:0] flushed_sum;

   // On redirect occ_after is exactly what gets thrown away: queued entries not
   // popped this cycle plus the outstanding read.
   assign flushed_sum = {1'b0, perf_flushed} + 33'(occ_after);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched <= '0;
         perf_flushed <= '0;
      end else begin
         if (pop && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
         if (redirect_valid) perf_flushed <= flushed_sum[32] ? '1 : flushed_sum[31:0];
      end
   end
`endif

endmodule
